// File: rtl/peak_finder.sv
// rtl/peak_finder.sv - threshold-crossing peak extractor with dead time
// Emits one amplitude/timestamp record per pulse above threshold.
module peak_finder #(
   parameter int SIZE_DATA  = 16,
   parameter int SIZE_TIME  = 16,
   parameter int DEAD_TIME  = 8,
   parameter int MAX_WIDTH  = 64,
   parameter int SIZE_COUNT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SIZE_DATA-1:0]  input_data,
   input  logic [SIZE_DATA-1:0]  threshold,
   output logic [SIZE_DATA-1:0]  peak_amplitude,
   output logic [SIZE_TIME-1:0]  peak_time,
   output logic                  peak_overflow,
   output logic                  peak_valid,
   output logic                  busy,
   output logic [SIZE_COUNT-1:0] event_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ABOVE = 2'd1;
   localparam logic [1:0] S_DEAD  = 2'd2;

   localparam int WW = $clog2(MAX_WIDTH + 1);
   localparam int DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
   localparam logic [WW-1:0] MAX_W     = WW'(MAX_WIDTH);
   localparam logic [WW-1:0] WIDTH_ONE = WW'(1);
   localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_TIME);
   localparam logic [DW-1:0] DEAD_ONE  = DW'(1);

   logic [1:0]           state;
   logic [SIZE_TIME-1:0] time_cnt;
   logic [SIZE_DATA-1:0] max_val;
   logic [SIZE_TIME-1:0] max_t;
   logic [WW-1:0]        width;
   logic [DW-1:0]        dead_cnt;
   logic                 above;
   logic                 close_event;

   assign above       = (input_data > threshold);
   // The closing sample never contributes to the record, even on overflow.
   assign close_event = (state == S_ABOVE) && (!above || (width == MAX_W));
   assign busy        = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         time_cnt       <= '0;
         max_val        <= '0;
         max_t          <= '0;
         width          <= '0;
         dead_cnt       <= '0;
         peak_amplitude <= '0;
         peak_time      <= '0;
         peak_overflow  <= 1'b0;
         peak_valid     <= 1'b0;
         event_count    <= '0;
      end else begin
         time_cnt   <= time_cnt + 1'b1;
         peak_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (above) begin
                  state   <= S_ABOVE;
                  max_val <= input_data;
                  max_t   <= time_cnt;
                  width   <= WIDTH_ONE;
               end
            end
            S_ABOVE: begin
               if (close_event) begin
                  peak_amplitude <= max_val;
                  peak_time      <= max_t;
                  peak_overflow  <= above;
                  peak_valid     <= 1'b1;
                  if (event_count != '1) begin
                     event_count <= event_count + 1'b1;
                  end
                  if (DEAD_TIME == 0) begin
                     state <= S_IDLE;
                  end else begin
                     state    <= S_DEAD;
                     dead_cnt <= DEAD_INIT;
                  end
               end else begin
                  width <= width + 1'b1;
                  // Strict compare keeps the earliest timestamp on a plateau.
                  if (input_data > max_val) begin
                     max_val <= input_data;
                     max_t   <= time_cnt;
                  end
               end
            end
            S_DEAD: begin
               dead_cnt <= dead_cnt - 1'b1;
               if (dead_cnt == DEAD_ONE) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_peak_finder.sv
// tb/tb_peak_finder.sv - self-checking bench for peak_finder
// Two instances (default and narrow/zero-dead-time) run against one event-level model.
module tb_peak_finder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] input_data;
   logic [15:0] threshold;

   logic [15:0] a_amp, a_time, a_cnt;
   logic        a_ovf, a_valid, a_busy;
   logic [15:0] b_amp;
   logic [3:0]  b_time;
   logic [1:0]  b_cnt;
   logic        b_ovf, b_valid, b_busy;

   logic [50:0] obs_a;
   logic [24:0] obs_b;
   assign obs_a = {a_amp, a_time, a_ovf, a_valid, a_busy, a_cnt};
   assign obs_b = {b_amp, b_time, b_ovf, b_valid, b_busy, b_cnt};

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   peak_finder #(
      .SIZE_DATA(16), .SIZE_TIME(16), .DEAD_TIME(8), .MAX_WIDTH(64), .SIZE_COUNT(16)
   ) dut_a (
      .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
      .peak_amplitude(a_amp), .peak_time(a_time), .peak_overflow(a_ovf),
      .peak_valid(a_valid), .busy(a_busy), .event_count(a_cnt)
   );

   peak_finder #(
      .SIZE_DATA(16), .SIZE_TIME(4), .DEAD_TIME(0), .MAX_WIDTH(4), .SIZE_COUNT(2)
   ) dut_b (
      .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
      .peak_amplitude(b_amp), .peak_time(b_time), .peak_overflow(b_ovf),
      .peak_valid(b_valid), .busy(b_busy), .event_count(b_cnt)
   );

   // Reference model: each event is the list of its samples; the record is derived
   // from that list when the event closes. e counts edges since reset release.
   int hist [0:131071];
   int g = 0;
   int e = 0;
   int m_dt    [2] = '{8, 0};
   int m_mw    [2] = '{64, 4};
   int m_cmax  [2] = '{65535, 3};
   int m_tmask [2] = '{65535, 15};
   bit m_in    [2];
   bit m_ovf   [2];
   bit m_valid [2];
   int m_g0 [2], m_e0 [2], m_len [2], m_resume [2];
   int m_amp [2], m_time [2], m_cnt [2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_in[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
         m_g0[i] = 0; m_e0[i] = 0; m_len[i] = 0; m_resume[i] = 0;
         m_amp[i] = 0; m_time[i] = 0; m_cnt[i] = 0;
      end
      e = 0;
   endfunction

   function automatic void model_edge(input int s, input int t);
      int best;
      int bt;
      hist[g] = s;
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 0;
         if (m_in[i]) begin
            if (s > t && m_len[i] < m_mw[i]) begin
               m_len[i]++;
            end else begin
               best = hist[m_g0[i]];
               bt   = 0;
               for (int k = 1; k < m_len[i]; k++) begin
                  if (hist[m_g0[i] + k] > best) begin
                     best = hist[m_g0[i] + k];
                     bt   = k;
                  end
               end
               m_amp[i]    = best;
               m_time[i]   = (m_e0[i] + bt) & m_tmask[i];
               m_ovf[i]    = (s > t);
               m_valid[i]  = 1;
               if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
               m_in[i]     = 0;
               m_resume[i] = e + m_dt[i] + 1;
            end
         end else if (e >= m_resume[i] && s > t) begin
            m_in[i]  = 1;
            m_g0[i]  = g;
            m_e0[i]  = e;
            m_len[i] = 1;
         end
      end
      g++;
      e++;
   endfunction

   function automatic logic [50:0] exp_a();
      logic bz;
      bz = m_in[0] || (e < m_resume[0]);
      return {m_amp[0][15:0], m_time[0][15:0], m_ovf[0], m_valid[0], bz, m_cnt[0][15:0]};
   endfunction

   function automatic logic [24:0] exp_b();
      logic bz;
      bz = m_in[1] || (e < m_resume[1]);
      return {m_amp[1][15:0], m_time[1][3:0], m_ovf[1], m_valid[1], bz, m_cnt[1][1:0]};
   endfunction

   task automatic step(input int s, input int t);
      input_data = s[15:0];
      threshold  = t[15:0];
      @(posedge clk);
      model_edge(s, t);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      total++;
      if (obs_a !== 51'd0 || obs_b !== 25'd0)
         $display("FAIL reset_state a=%h b=%h want 0", obs_a, obs_b);
      else passed++;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_single_pulse();
      int seq [5] = '{0, 150, 300, 250, 90};
      while (e < 10) step(0, 100);
      for (int k = 0; k < 5; k++) begin
         step(seq[k], 100);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL single e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
      total++;
      if (!(a_valid === 1'b1 && a_amp === 16'd300 && a_time === 16'd12 && a_ovf === 1'b0 && a_cnt === 16'd1))
         $display("FAIL single_record v=%b amp=%0d t=%0d ovf=%b cnt=%0d want 1/300/12/0/1",
                  a_valid, a_amp, a_time, a_ovf, a_cnt);
      else passed++;
      for (int k = 0; k < 12; k++) begin
         step(0, 100);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL single_dead e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
   endtask

   task automatic test_plateau();
      int seq [3] = '{200, 200, 50};
      int first_t;
      first_t = e & 65535;
      for (int k = 0; k < 3; k++) begin
         step(seq[k], 100);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL plateau e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
      total++;
      if (!(a_valid === 1'b1 && a_amp === 16'd200 && a_time === first_t[15:0] && a_cnt === 16'd2))
         $display("FAIL plateau_record amp=%0d t=%0d cnt=%0d want 200/%0d/2", a_amp, a_time, a_cnt, first_t);
      else passed++;
      for (int k = 0; k < 12; k++) step(0, 100);
   endtask

   task automatic test_dead_time();
      int seq [10] = '{0, 0, 180, 0, 0, 0, 0, 0, 220, 0};
      step(150, 100);
      step(0, 100);
      total++;
      if (!(a_valid === 1'b1 && a_cnt === 16'd3))
         $display("FAIL dead_first v=%b cnt=%0d want 1/3", a_valid, a_cnt);
      else passed++;
      for (int k = 0; k < 10; k++) begin
         step(seq[k], 100);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL dead e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
         if (k == 2) begin
            total++;
            if (a_valid !== 1'b0 || a_cnt !== 16'd3 || a_busy !== 1'b1)
               $display("FAIL dead_ignore v=%b cnt=%0d busy=%b want 0/3/1", a_valid, a_cnt, a_busy);
            else passed++;
         end
      end
      total++;
      if (!(a_valid === 1'b1 && a_amp === 16'd220 && a_cnt === 16'd4))
         $display("FAIL dead_capture v=%b amp=%0d cnt=%0d want 1/220/4", a_valid, a_amp, a_cnt);
      else passed++;
      for (int k = 0; k < 12; k++) step(0, 100);
   endtask

   task automatic test_overflow();
      int strobes;
      strobes = 0;
      for (int k = 0; k < 65; k++) begin
         step(500, 100);
         if (a_valid === 1'b1) strobes++;
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL overflow e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
      total++;
      if (!(strobes == 1 && a_valid === 1'b1 && a_ovf === 1'b1 && a_amp === 16'd500 && a_cnt === 16'd5))
         $display("FAIL overflow_record n=%0d v=%b ovf=%b amp=%0d cnt=%0d want 1/1/1/500/5",
                  strobes, a_valid, a_ovf, a_amp, a_cnt);
      else passed++;
      for (int k = 0; k < 9; k++) begin
         step(500, 100);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL overflow_dead e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
      step(0, 100);
      total++;
      if (!(a_valid === 1'b1 && a_ovf === 1'b0 && a_amp === 16'd500 && a_cnt === 16'd6))
         $display("FAIL overflow_retrigger v=%b ovf=%b amp=%0d cnt=%0d want 1/0/500/6", a_valid, a_ovf, a_amp, a_cnt);
      else passed++;
      for (int k = 0; k < 12; k++) step(0, 100);
   endtask

   task automatic test_reset_mid_event();
      int seq [4] = '{0, 0, 150, 0};
      step(0, 100);
      step(200, 100);
      step(300, 100);
      reset = 1'b1;
      #2;
      total++;
      if (obs_a !== 51'd0 || obs_b !== 25'd0)
         $display("FAIL reset_mid a=%h b=%h want 0", obs_a, obs_b);
      else passed++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         step(seq[k], 100);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL reset_after e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
      total++;
      if (!(a_valid === 1'b1 && a_amp === 16'd150 && a_time === 16'd2 && a_cnt === 16'd1))
         $display("FAIL reset_recover v=%b amp=%0d t=%0d cnt=%0d want 1/150/2/1", a_valid, a_amp, a_time, a_cnt);
      else passed++;
      for (int k = 0; k < 12; k++) step(0, 100);
   endtask

   task automatic test_random();
      int t;
      t = 150;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 15) == 0) t = $urandom_range(50, 300);
         step($urandom_range(0, 400), t);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL random e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
      for (int k = 0; k < 80; k++) step(0, 100);
   endtask

   task automatic test_saturation();
      int strobes;
      strobes = 0;
      for (int n = 0; n < 5; n++) begin
         step(150, 100);
         step(0, 100);
         if (b_valid === 1'b1) strobes++;
         for (int k = 0; k < 10; k++) step(0, 100);
      end
      total++;
      if (strobes != 5 || b_cnt !== 2'd3)
         $display("FAIL saturation strobes=%0d cnt=%0d want 5/3", strobes, b_cnt);
      else passed++;
   endtask

   task automatic test_wrap();
      int seq [5] = '{150, 200, 250, 400, 50};
      while ((e & 65535) != 65534) step(0, 100);
      for (int k = 0; k < 5; k++) begin
         step(seq[k], 100);
         total++;
         if (obs_a !== exp_a() || obs_b !== exp_b())
            $display("FAIL wrap e=%0d a=%h/%h b=%h/%h", e, obs_a, exp_a(), obs_b, exp_b());
         else passed++;
      end
      total++;
      if (!(a_valid === 1'b1 && a_amp === 16'd400 && a_time === 16'd1))
         $display("FAIL wrap_record v=%b amp=%0d t=%0d want 1/400/1", a_valid, a_amp, a_time);
      else passed++;
   endtask

   initial begin
      reset      = 1'b1;
      input_data = '0;
      threshold  = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset();
      test_single_pulse();
      test_plateau();
      test_dead_time();
      test_overflow();
      test_reset_mid_event();
      test_random();
      test_saturation();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
